palu_seq: RTL and testbench
===========================

Name: palu_seq

Overview:
- Parametrised, registered successor to the 8-bit partial ALU. Operand width is WIDTH; a 3-bit opcode selects from 8 operations.
- Adds a valid/ready handshake on both input and output, result flags, and two iterative multi-cycle operations: shift-add multiply and bit-serial left shift.
- Sits between an operand-issue stage and a result consumer. Only one operation is in flight at a time.

Parameters:
- WIDTH, 8, operand/result width in bits. Must be ≥ 2 and a power of two.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from b[SHW-1:0]. Derived; do not override.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands/opcode presented.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; b[SHW-1:0] is the shift amount for SHL.
- sel  in  3  opcode.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result.
- f  out  WIDTH  result.
- ovf  out  1  overflow/carry/borrow flag.
- zero  out  1  1 when f == 0.
- busy  out  1  multi-cycle operation in progress.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; f=0, ovf=0, zero=0, out_valid=0, busy=0.
  - in_ready=0 while rst is high.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE). Acceptance occurs on in_valid & in_ready at a rising edge; a, b and sel are captured at that edge.
  - IDLE + accept, single-cycle opcode: go to DONE at the same edge, with f/ovf/zero registered. out_valid is high 1 cycle after acceptance.
  - IDLE + accept, MUL: go to BUSY, busy=1. Perform WIDTH iterations, 1 per cycle, then go to DONE. out_valid is high WIDTH+1 cycles after acceptance.
  - IDLE + accept, SHL: if shamt==0, go directly to DONE (latency 1). Otherwise go to BUSY for shamt cycles, then DONE (latency shamt+1).
  - DONE: f/ovf/zero/out_valid are held stable while out_ready=0. On out_ready=1: out_valid drops at the next edge and state returns to IDLE.
  - in_valid is ignored outside IDLE; there is no queuing.
  - Peak throughput is 1 op per 2 cycles.
  - A change on a, b or sel after acceptance has no effect on the running operation.
- Opcodes (all arithmetic is unsigned, modulo 2^WIDTH):
  - 0 ADD: f=a+b; ovf=carry out of bit WIDTH-1.
  - 1 NOT: f=~b; ovf=0.
  - 2 AND: f=a&b; ovf=0.
  - 3 OR: f=a|b; ovf=0.
  - 4 SUB: f=a-b; ovf=1 iff a<b (borrow).
  - 5 XOR: f=a^b; ovf=0.
  - 6 MUL: f=low WIDTH bits of a*b; ovf=1 iff the high WIDTH bits are nonzero.
    - Implementation: 2*WIDTH-bit accumulator, one shift-add step per cycle, LSB-first over b.
  - 7 SHL: f=a<<shamt, one bit per cycle; ovf=1 iff any 1 bit was shifted out. shamt = b[SHW-1:0].
- zero is computed from the final f for every opcode.
- busy=1 exactly while state==BUSY.
- Reset mid-operation (BUSY or DONE): the operation is abandoned and all outputs return to their reset values immediately. No partial result is ever presented.
- in_valid asserted in the same cycle that rst deasserts: not accepted, because in_ready was 0 during reset.

Decomposition:
- Package palu_pkg:
  - opcode localparams OP_ADD=3'd0, OP_NOT, OP_AND, OP_OR, OP_SUB, OP_XOR, OP_MUL, OP_SHL=3'd7;
  - FSM state encoding ST_IDLE/ST_BUSY/ST_DONE.
- Sub-module palu_iter: owns the iterative datapath (multiply accumulator, shift register, iteration counter).
  - Inputs: start, op_is_mul, a, b.
  - Outputs: done, result, ovf.
- Single-cycle ops and the FSM stay in palu_seq.

Test Plan (WIDTH=8):
- ADD a=0x53, b=0x94, out_ready=1 → out_valid 1 cycle after acceptance; f=0xE7, ovf=0, zero=0. Then ADD a=0xD5, b=0x78 → f=0x4D, ovf=1.
- SUB a=0x10, b=0x20 → f=0xF0, ovf=1. NOT b=0xAA → f=0x55. AND a=0xB8, b=0xE7 → f=0xA0. OR a=0xB5, b=0xD7 → f=0xF7.
- Multi-cycle ops:
  - MUL a=0x0F, b=0x11 → busy for 8 cycles, out_valid 9 cycles after acceptance, f=0xFF, ovf=0.
  - MUL a=0x10, b=0x10 → f=0x00, ovf=1, zero=1.
- Shifts:
  - SHL a=0x81, b=0x03 → out_valid 4 cycles after acceptance; f=0x08, ovf=1.
  - SHL with b=0x00 → latency 1, f=a, ovf=0.
- Backpressure: complete ADD with out_ready=0 for 5 cycles while in_valid=1 with new operands → f/out_valid held, in_ready=0, second op not accepted. Raise out_ready → IDLE next cycle, then the new op is accepted.
- Reset mid-op: assert rst 3 cycles into a MUL → f=0, out_valid=0, busy=0 immediately. After release, issue ADD 0x01+0x01 → f=0x02 with normal latency.

Source files
------------

// File: rtl/palu_pkg.sv
// palu_pkg: shared definitions for the sequential partial ALU.
//   - 3-bit opcode encodings (OP_ADD .. OP_SHL)
//   - control FSM state encoding (ST_IDLE / ST_BUSY / ST_DONE)
package palu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_NOT = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/palu_iter.sv
// palu_iter: iterative datapath for the two multi-cycle opcodes.
//   MUL: 2*WIDTH-bit shift-add accumulator, one partial product per cycle,
//        LSB-first over b, WIDTH iterations.
//   SHL: shift register moving a left one bit per cycle, b[SHW-1:0] steps,
//        with a sticky flag for any 1 shifted out of the MSB.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (control only)
//   start      load operands and begin iterating (on the acceptance edge)
//   op_is_mul  1 = multiply, 0 = shift left (sampled with start)
//   a, b       operands (sampled with start)
//   done       the coming clock edge performs the final iteration
//   result     value after the final iteration (valid while done=1)
//   ovf        flag after the final iteration (valid while done=1)
module palu_iter #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_is_mul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  // One extra bit so the counter can hold WIDTH itself for MUL.
  localparam int CW = SHW + 1;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 mul_q, mul_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     sh_q, sh_d;
  logic                 shovf_q, shovf_d;

  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     sh_step;
  logic                 shovf_step;
  logic                 active;

  assign active = (cnt_q != '0);

  // Value each register takes on an iteration; also drives result/ovf so the
  // final iteration's outcome is visible in the same cycle it is registered.
  assign acc_step   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign sh_step    = {sh_q[WIDTH-2:0], 1'b0};
  assign shovf_step = shovf_q | sh_q[WIDTH-1];

  always_comb begin
    cnt_d    = cnt_q;
    mul_d    = mul_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sh_d     = sh_q;
    shovf_d  = shovf_q;
    if (start) begin
      cnt_d    = op_is_mul ? CW'(WIDTH) : CW'(b[SHW-1:0]);
      mul_d    = op_is_mul;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      sh_d     = a;
      shovf_d  = 1'b0;
    end else if (active) begin
      // Both paths step together; only the one selected by mul_q is reported.
      cnt_d    = cnt_q - CW'(1);
      acc_d    = acc_step;
      mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      sh_d     = sh_step;
      shovf_d  = shovf_step;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      mul_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mul_q <= mul_d;
    end
  end

  // Datapath registers carry no reset: nothing reads them unless cnt_q != 0,
  // and cnt_q is cleared by reset.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    sh_q     <= sh_d;
    shovf_q  <= shovf_d;
  end

  assign done   = (cnt_q == CW'(1));
  assign result = mul_q ? acc_step[WIDTH-1:0] : sh_step;
  assign ovf    = mul_q ? (|acc_step[2*WIDTH-1:WIDTH]) : shovf_step;

endmodule

// File: rtl/palu_seq.sv
// palu_seq: registered partial ALU with valid/ready handshakes on both sides.
// One operation in flight at a time; single-cycle ops complete on the
// acceptance edge, MUL and non-zero SHL run through palu_iter.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (accept on in_valid & in_ready)
//   a, b, sel           operands and opcode; b[SHW-1:0] is the SHL amount
//   out_valid/out_ready result handshake
//   f, ovf, zero        result, overflow/carry/borrow flag, f==0 flag
//   busy                multi-cycle operation in progress
module palu_seq
  import palu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic             needs_iter;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_result;
  logic             iter_ovf;
  logic [WIDTH:0]   alu_res;

  // Single-cycle result as {ovf, f}. SHL only lands here with a zero shift
  // amount, so it passes a through unchanged.
  function automatic logic [WIDTH:0] alu_single(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH:0] r;
    r = '0;
    case (op)
      OP_ADD: r = {1'b0, x} + {1'b0, y};
      OP_NOT: r = {1'b0, ~y};
      OP_AND: r = {1'b0, x & y};
      OP_OR:  r = {1'b0, x | y};
      OP_SUB: r = {(x < y), x - y};
      OP_XOR: r = {1'b0, x ^ y};
      OP_SHL: r = {1'b0, x};
      default: r = '0;
    endcase
    return r;
  endfunction

  // in_ready is gated by rst so nothing can be accepted while reset is held.
  assign in_ready   = (state_q == ST_IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign needs_iter = (sel == OP_MUL) || ((sel == OP_SHL) && (b[SHW-1:0] != '0));
  assign alu_res    = alu_single(sel, a, b);

  palu_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (iter_start),
    .op_is_mul (sel == OP_MUL),
    .a         (a),
    .b         (b),
    .done      (iter_done),
    .result    (iter_result),
    .ovf       (iter_ovf)
  );

  always_comb begin
    state_d    = state_q;
    f_d        = f_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    iter_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (needs_iter) begin
            iter_start = 1'b1;
            state_d    = ST_BUSY;
          end else begin
            f_d     = alu_res[WIDTH-1:0];
            ovf_d   = alu_res[WIDTH];
            zero_d  = (alu_res[WIDTH-1:0] == '0);
            state_d = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (iter_done) begin
          f_d     = iter_result;
          ovf_d   = iter_ovf;
          zero_d  = (iter_result == '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      f_q     <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_BUSY);
  assign f         = f_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_palu_seq.sv
// Scoreboard bench for palu_seq (WIDTH=8): stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares on each output handshake.
module tb_palu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [2:0]   sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic         ovf, zero, busy;

  typedef struct {
    logic [W-1:0] f;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  palu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .ovf       (ovf),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every completed output handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(f), 32'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("f", 32'(f), 32'(e.f));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("zero", 32'(zero), 32'(e.zero));
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] ef, input logic eo);
    exp_t e;
    e.f = ef; e.ovf = eo; e.zero = (ef == '0);
    exp_q.push_back(e);
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // Issue one op, then measure latency to out_valid and the number of busy cycles.
  task automatic do_op(input string name, input logic [2:0] s, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic [W-1:0] ef, input logic eo,
                       input int elat);
    int n;
    int bc;
    wait_in_ready();
    sel = s; a = aa; b = bb; in_valid = 1'b1;
    push_exp(ef, eo);
    @(posedge clk); #1;
    // Scramble inputs: the running op must use the captured values.
    in_valid = 1'b0; a = ~aa; b = ~bb; sel = s ^ 3'd1;
    n = 1; bc = 0;
    while (!out_valid && n < 40) begin
      if (busy) bc++;
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(elat));
    check({name, "_busy_cycles"}, 32'(bc), 32'(elat - 1));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sel = '0;
    #1;
    check("rst_f", 32'(f), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_ovf_zero", 32'({ovf, zero}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    do_op("add1", 3'd0, 8'h53, 8'h94, 8'hE7, 1'b0, 1);
    do_op("add2", 3'd0, 8'hD5, 8'h78, 8'h4D, 1'b1, 1);
    do_op("add_wrap", 3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1);
    do_op("sub", 3'd4, 8'h10, 8'h20, 8'hF0, 1'b1, 1);
    do_op("sub_eq", 3'd4, 8'h33, 8'h33, 8'h00, 1'b0, 1);
    do_op("not", 3'd1, 8'h12, 8'hAA, 8'h55, 1'b0, 1);
    do_op("and", 3'd2, 8'hB8, 8'hE7, 8'hA0, 1'b0, 1);
    do_op("or", 3'd3, 8'hB5, 8'hD7, 8'hF7, 1'b0, 1);
    do_op("xor", 3'd5, 8'h3C, 8'hC3, 8'hFF, 1'b0, 1);
    do_op("mul1", 3'd6, 8'h0F, 8'h11, 8'hFF, 1'b0, 9);
    do_op("mul2", 3'd6, 8'h10, 8'h10, 8'h00, 1'b1, 9);
    do_op("mul3", 3'd6, 8'h0D, 8'h0B, 8'h8F, 1'b0, 9);
    do_op("shl3", 3'd7, 8'h81, 8'h03, 8'h08, 1'b1, 4);
    do_op("shl0", 3'd7, 8'h5A, 8'h00, 8'h5A, 1'b0, 1);
    do_op("shl_lowbits", 3'd7, 8'h40, 8'h09, 8'h80, 1'b0, 2);

    // Backpressure: result held, second op presented but not taken.
    wait_in_ready();
    out_ready = 1'b0;
    sel = 3'd0; a = 8'h22; b = 8'h11; in_valid = 1'b1;
    push_exp(8'h33, 1'b0);
    @(posedge clk); #1;
    sel = 3'd5; a = 8'h0F; b = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_f", 32'(f), 32'h33);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    push_exp(8'hF0, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Reset three cycles into a MUL: no result may ever appear for it.
    wait_in_ready();
    sel = 3'd6; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_f", 32'(f), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op("add_after_rst", 3'd0, 8'h01, 8'h01, 8'h02, 1'b0, 1);

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

endmodule
